// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and default sizing.
package arb_pkg;

  localparam int ARB_N        = 8;
  localparam int ARB_IDX_W    = 3;
  localparam int ARB_MAX_HOLD = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational circular-priority picker: first set req bit at or after start, wrapping N-1 -> 0.
module rr_pick8
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int IDX_W = ARB_IDX_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] pos;

  // pos wraps naturally because N is exactly 2**IDX_W.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = start;
    for (int i = 0; i < N; i++) begin
      pos = start + IDX_W'(i);
      if (!found && req[pos]) begin
        found       = 1'b1;
        idx         = pos;
        onehot[pos] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with registered one-hot grant, index and valid.
// Optional grant tenure limit with preemption when RR_ARBITER8_TIMEOUT_EN is defined.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDX_W    = ARB_IDX_W,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt,
  output logic             dbg_state,
  output logic [IDX_W-1:0] dbg_ptr
);

  if (N < 2 || N > 8 || (1 << IDX_W) != N || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_params
    $error("rr_arbiter8: illegal parameter combination");
  end

  // Handshake: a requester keeps req[i] high while it wants the resource;
  // gnt[i] is its registered go-ahead, dropped on the edge that samples req[i] low.

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             grant_now;

  logic [N-1:0]     pick_req;
  logic [N-1:0]     win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;

`ifdef RR_ARBITER8_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       pre_q, pre_d;
  logic       hold_expired;

  assign hold_expired = (hold_q == 8'(MAX_HOLD - 1));
`endif

  // ptr always sits at holder+1 while BUSY, so one search start serves both
  // the idle case and the "search from h+1" case. Masking the holder keeps it
  // last in line when it is preempted.
  assign pick_req = req & ~gnt_q;

  rr_pick8 #(
    .N    (N),
    .IDX_W(IDX_W)
  ) u_pick (
    .req   (pick_req),
    .start (ptr_q),
    .onehot(win_oh),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    grant_now = 1'b0;
`ifdef RR_ARBITER8_TIMEOUT_EN
    hold_d    = hold_q;
    pre_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        grant_now = win_any;
      end
      BUSY: begin
        if (!req[idx_q]) begin
          if (win_any) begin
            grant_now = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end
`ifdef RR_ARBITER8_TIMEOUT_EN
        else if (hold_expired) begin
          if (win_any) begin
            grant_now = 1'b1;
            pre_d     = 1'b1;
          end else begin
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase

    if (grant_now) begin
      state_d = BUSY;
      gnt_d   = win_oh;
      idx_d   = win_idx;
      valid_d = 1'b1;
      ptr_d   = win_idx + IDX_W'(1);
`ifdef RR_ARBITER8_TIMEOUT_EN
      hold_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
`ifdef RR_ARBITER8_TIMEOUT_EN
      hold_q  <= '0;
      pre_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
`ifdef RR_ARBITER8_TIMEOUT_EN
      hold_q  <= hold_d;
      pre_q   <= pre_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

`ifdef RR_ARBITER8_TIMEOUT_EN
  assign preempt = pre_q;
`else
  assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus randomized traffic against a holder/pointer model.
module tb_rr_arbiter8;
  import arb_pkg::*;

  localparam int N           = 8;
  localparam int IDX_W       = 3;
  localparam int TB_MAX_HOLD = 4;

  // clock / reset
  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             preempt;
  logic             dbg_state;
  logic [IDX_W-1:0] dbg_ptr;

  always #5 clk = ~clk;

  rr_arbiter8 #(
    .N       (N),
    .IDX_W   (IDX_W),
    .MAX_HOLD(TB_MAX_HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .preempt  (preempt),
    .dbg_state(dbg_state),
    .dbg_ptr  (dbg_ptr)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: holder is -1 when nothing is granted
  int m_holder = -1;
  int m_ptr    = 0;
  int m_idx    = 0;
  int m_ten    = 0;
  int m_pre    = 0;

  function automatic int search(input logic [7:0] r, input int start);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (start + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic m_grant(input int w);
    m_holder = w;
    m_idx    = w;
    m_ptr    = (w + 1) % N;
    m_ten    = 0;
  endtask

  task automatic model_edge(input logic r, input logic [7:0] q);
    int w;
    m_pre = 0;
    if (r) begin
      m_holder = -1;
      m_ptr    = 0;
      m_idx    = 0;
      m_ten    = 0;
    end else if (m_holder < 0) begin
      w = search(q, m_ptr);
      if (w >= 0) m_grant(w);
    end else if (!q[m_holder]) begin
      w = search(q, (m_holder + 1) % N);
      if (w >= 0) m_grant(w);
      else m_holder = -1;
    end
`ifdef RR_ARBITER8_TIMEOUT_EN
    else if (m_ten == TB_MAX_HOLD - 1) begin
      w = search(q & ~(8'h01 << m_holder), (m_holder + 1) % N);
      if (w >= 0) begin
        m_grant(w);
        m_pre = 1;
      end else begin
        m_ten = 0;
      end
    end else begin
      m_ten++;
    end
`endif
  endtask

  // scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs at the falling edge, model the rising edge, sample at the next falling edge
  task automatic step(input logic r, input logic [7:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    model_edge(r, q);
    @(negedge clk);
    chk("gnt", 32'(gnt), (m_holder >= 0) ? 32'(1 << m_holder) : 32'h0);
    chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
    chk("gnt_valid", 32'(gnt_valid), 32'(m_holder >= 0));
    chk("preempt", 32'(preempt), 32'(m_pre));
    chk("state", 32'(dbg_state), 32'(m_holder >= 0));
    chk("ptr", 32'(dbg_ptr), 32'(m_ptr));
  endtask

  initial begin
    logic [7:0] q;
    rst = 1'b1;
    req = '0;
    @(negedge clk);

    // reset dominates pending requests
    step(1'b1, 8'hFF);
    step(1'b1, 8'hFF);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(gnt_valid), 32'h0);
    step(1'b0, 8'hFF);
    chk("rst_rel_gnt", 32'(gnt), 32'h01);
    chk("rst_rel_idx", 32'(gnt_idx), 32'h0);

    // rotation: each holder drops its request for one cycle
    for (int i = 0; i < N; i++) begin
      step(1'b0, 8'hFF & ~(8'h01 << i));
      chk("rot_gnt", 32'(gnt), 32'(1 << ((i + 1) % N)));
    end

    // fairness after wrap
    step(1'b1, 8'h00);
    step(1'b0, 8'h40);
    chk("fair_h6", 32'(gnt), 32'h40);
    step(1'b0, 8'h03);
    chk("fair_g0", 32'(gnt), 32'h01);
    step(1'b0, 8'h43);
    chk("fair_hold0", 32'(gnt), 32'h01);
    step(1'b0, 8'h42);
    chk("fair_g1", 32'(gnt), 32'h02);
    step(1'b0, 8'h40);
    chk("fair_g6", 32'(gnt), 32'h40);

    // single requester then idle
    step(1'b1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h10);
      chk("single_gnt", 32'(gnt), 32'h10);
      chk("single_idx", 32'(gnt_idx), 32'h4);
    end
    step(1'b0, 8'h00);
    chk("single_idle_gnt", 32'(gnt), 32'h0);
    chk("single_idle_idx", 32'(gnt_idx), 32'h4);
    chk("single_idle_st", 32'(dbg_state), 32'(IDLE));

    // reset mid-grant
    step(1'b1, 8'h00);
    step(1'b0, 8'h08);
    chk("mid_h3", 32'(gnt), 32'h08);
    step(1'b1, 8'h08);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    step(1'b0, 8'h08);
    chk("mid_regrant", 32'(gnt), 32'h08);
    chk("mid_ptr", 32'(dbg_ptr), 32'h4);

    // tenure limit
    step(1'b1, 8'h00);
`ifdef RR_ARBITER8_TIMEOUT_EN
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 8'h03);
      chk("to_gnt", 32'(gnt), ((c / TB_MAX_HOLD) % 2 != 0) ? 32'h02 : 32'h01);
      chk("to_pre", 32'(preempt), 32'((c > 0) && (c % TB_MAX_HOLD == 0)));
    end
    step(1'b1, 8'h00);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 8'h01);
      chk("to_solo_gnt", 32'(gnt), 32'h01);
      chk("to_solo_pre", 32'(preempt), 32'h0);
    end
`else
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 8'h03);
      chk("notimeout_gnt", 32'(gnt), 32'h01);
      chk("notimeout_pre", 32'(preempt), 32'h0);
    end
`endif

    // randomized traffic
    q = 8'h00;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) q = 8'($urandom_range(0, 255));
      else q = q ^ (8'h01 << $urandom_range(0, 7));
      if (m_holder >= 0 && $urandom_range(0, 2) == 0) q[m_holder] = 1'b0;
      step(($urandom_range(0, 39) == 0), q);
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
